// File: rtl/string_typewriter.sv
// Typewriter-style text overlay: reveals a TEXT_SIZE_X x TEXT_SIZE_Y box of glyphs one
// character per FRAMES_PER_CHAR frames, then optionally blinks it; the bus is delayed 2 clocks.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`define VGA_HCOUNT 37:27
`define VGA_VCOUNT 26:16
`define VGA_HSYNC 15
`define VGA_VSYNC 14
`define VGA_HBLNK 13
`define VGA_VBLNK 12
`define VGA_RGB 11:0
`define VGA_MERGE(hc, vc, hs, vs, hb, vb, rgb) {hc, vc, hs, vs, hb, vb, rgb}
`endif

module string_typewriter #(
  parameter logic [11:0] TEXT_COLOUR     = 12'hFFF,
  parameter int          FONT_SIZE       = 2,
  parameter int          TEXT_POS_X      = 0,
  parameter int          TEXT_POS_Y      = 0,
  parameter int          TEXT_SIZE_X     = 16,
  parameter int          TEXT_SIZE_Y     = 6,
  parameter int          FRAMES_PER_CHAR = 4,
  parameter int          BLINK_FRAMES    = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     module_en,
  input  logic                     start,
  input  logic                     skip,
  input  logic [`VGA_BUS_SIZE-1:0] vga_bus_in,
  input  logic [6:0]               char_code,
  output logic [7:0]               char_xy,
  output logic [`VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic                     done
);

  localparam int SH = FONT_SIZE - 1;
  localparam int S  = 1 << SH;
  localparam logic signed [12:0] POS_X = 13'(TEXT_POS_X);
  localparam logic signed [12:0] POS_Y = 13'(TEXT_POS_Y);
  localparam logic signed [12:0] BOX_W = 13'(TEXT_SIZE_X * 8 * S);
  localparam logic signed [12:0] BOX_H = 13'(TEXT_SIZE_Y * 16 * S);
  localparam logic [8:0]  N          = 9'(TEXT_SIZE_X * TEXT_SIZE_Y);
  localparam logic [15:0] FPC_LAST   = 16'(FRAMES_PER_CHAR - 1);
  localparam logic [15:0] BLINK_LAST = 16'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

  typedef enum logic [1:0] {IDLE, REVEAL, SHOW} state_t;

  function automatic logic [7:0] font_line(input logic [10:0] addr);
    logic [127:0] g;
    case (addr[10:4])
      7'h30:   g = 128'h0000_7CC6_CEDE_F6E6_C6C6_7C00_0000_0000;
      7'h41:   g = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
      7'h48:   g = 128'h0000_C6C6_C6C6_FEC6_C6C6_C6C6_0000_0000;
      7'h49:   g = 128'h0000_3C18_1818_1818_1818_183C_0000_0000;
      7'h55:   g = 128'h0000_C6C6_C6C6_C6C6_C6C6_C67C_0000_0000;
      7'h7F:   g = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
      default: g = '0;
    endcase
    return g[127 - 8 * int'(addr[3:0]) -: 8];
  endfunction

  logic [10:0] hcount, vcount;
  logic        vblnk;
  assign hcount = vga_bus_in[`VGA_HCOUNT];
  assign vcount = vga_bus_in[`VGA_VCOUNT];
  assign vblnk  = vga_bus_in[`VGA_VBLNK];

  state_t      state, state_nxt;
  logic [8:0]  reveal_cnt, reveal_nxt;
  logic [15:0] frame_cnt, frame_nxt;
  logic [15:0] blink_cnt, blink_cnt_nxt;
  logic        blink_on, blink_on_nxt;
  logic        vblnk_q, tick;

  // ---- stage 0: box position, glyph cell and bit select (shifts via part-selects)
  logic signed [12:0] dx, dy;
  logic               in_box, pixel_visible;
  logic [3:0]         col, row, char_line;
  logic [2:0]         bit_sel;
  logic [8:0]         idx;

  assign dx        = $signed({2'b00, hcount}) - POS_X;
  assign dy        = $signed({2'b00, vcount}) - POS_Y;
  assign in_box    = (dx >= 13'sd0) && (dx < BOX_W) && (dy >= 13'sd0) && (dy < BOX_H);
  assign col       = dx[3 + SH +: 4];
  assign row       = dy[4 + SH +: 4];
  assign char_line = dy[SH +: 4];
  assign bit_sel   = ~dx[SH +: 3];
  assign idx       = 9'(row * TEXT_SIZE_X) + 9'(col);
  assign char_xy   = {col, row};
  assign tick      = vblnk & ~vblnk_q;

  assign pixel_visible = in_box && (idx < reveal_cnt) &&
                         ((state != SHOW) || blink_on || (BLINK_FRAMES == 0));

  // ---- stage 1: bus copy, registered font line, visibility and bit select
  logic [`VGA_BUS_SIZE-1:0] bus_p1;
  logic [7:0]               font_p1;
  logic [2:0]               bit_p1;
  logic                     vld_p1;
  logic [11:0]              rgb_p2;

  // module_en is taken here, at stage 2, so pixels in flight are never overridden once it drops
  assign rgb_p2 = (module_en && vld_p1 && font_p1[bit_p1]) ? TEXT_COLOUR : bus_p1[`VGA_RGB];

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_p1      <= '0;
      font_p1     <= '0;
      bit_p1      <= '0;
      vld_p1      <= 1'b0;
      vga_bus_out <= '0;
    end else begin
      bus_p1      <= vga_bus_in;
      font_p1     <= font_line({char_code, char_line});
      bit_p1      <= bit_sel;
      vld_p1      <= pixel_visible;
      // ---- stage 2: merged output bus
      vga_bus_out <= `VGA_MERGE(bus_p1[`VGA_HCOUNT], bus_p1[`VGA_VCOUNT], bus_p1[`VGA_HSYNC],
                                bus_p1[`VGA_VSYNC], bus_p1[`VGA_HBLNK], bus_p1[`VGA_VBLNK], rgb_p2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      reveal_cnt <= '0;
      frame_cnt  <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      done       <= 1'b0;
      vblnk_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      reveal_cnt <= reveal_nxt;
      frame_cnt  <= frame_nxt;
      blink_cnt  <= blink_cnt_nxt;
      blink_on   <= blink_on_nxt;
      done       <= (state_nxt == SHOW);
      vblnk_q    <= vblnk;
    end
  end

  // Priority: module_en low, then start (a tick in the start cycle is dropped), then skip
  always_comb begin
    state_nxt     = state;
    reveal_nxt    = reveal_cnt;
    frame_nxt     = frame_cnt;
    blink_cnt_nxt = blink_cnt;
    blink_on_nxt  = blink_on;
    if (!module_en) begin
      state_nxt     = IDLE;
      reveal_nxt    = '0;
      frame_nxt     = '0;
      blink_cnt_nxt = '0;
      blink_on_nxt  = 1'b1;
    end else if (start) begin
      state_nxt  = REVEAL;
      reveal_nxt = '0;
      frame_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          reveal_nxt = '0;
          frame_nxt  = '0;
        end
        REVEAL: begin
          if (skip || (tick && frame_cnt == FPC_LAST && reveal_cnt + 9'd1 == N)) begin
            state_nxt     = SHOW;
            reveal_nxt    = N;
            frame_nxt     = '0;
            blink_cnt_nxt = '0;
            blink_on_nxt  = 1'b1;
          end else if (tick) begin
            if (frame_cnt == FPC_LAST) begin
              frame_nxt  = '0;
              reveal_nxt = reveal_cnt + 9'd1;
            end else begin
              frame_nxt = frame_cnt + 16'd1;
            end
          end
        end
        SHOW: begin
          if ((BLINK_FRAMES > 0) && tick) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt_nxt = '0;
              blink_on_nxt  = ~blink_on;
            end else begin
              blink_cnt_nxt = blink_cnt + 16'd1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_string_typewriter.sv
// Bench for string_typewriter: per-cycle bus scoreboard (2-clock delay), pixel vector table,
// and hand-written sequences for reveal timing, skip/restart, blink, enable and reset.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`define VGA_HCOUNT 37:27
`define VGA_VCOUNT 26:16
`define VGA_HSYNC 15
`define VGA_VSYNC 14
`define VGA_HBLNK 13
`define VGA_VBLNK 12
`define VGA_RGB 11:0
`define VGA_MERGE(hc, vc, hs, vs, hb, vb, rgb) {hc, vc, hs, vs, hb, vb, rgb}
`endif

module tb_string_typewriter;
  localparam logic [11:0] COLOUR = 12'hF80;
  localparam logic [11:0] BG     = 12'h123;

  logic clk = 1'b0;
  logic rst = 1'b1, module_en = 1'b0, start = 1'b0, skip = 1'b0;
  logic [10:0] hc = '0, vc = '0;
  logic hs = 1'b0, vs = 1'b0, hb = 1'b0, vb = 1'b0;
  logic [11:0] rgb_v = '0;
  logic [`VGA_BUS_SIZE-1:0] vga_bus_in, vga_bus_out;
  logic [6:0] char_code;
  logic [7:0] char_xy;
  logic done;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct { logic [`VGA_BUS_SIZE-1:0] exp; } sb_t;
  sb_t q[$];

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        lit;
    logic        xy_chk;
    logic [7:0]  xy;
  } pix_t;

  assign vga_bus_in = `VGA_MERGE(hc, vc, hs, vs, hb, vb, rgb_v);
  assign char_code  = 7'h55;

  string_typewriter #(
    .TEXT_COLOUR(COLOUR), .FONT_SIZE(2), .TEXT_POS_X(247), .TEXT_POS_Y(200),
    .TEXT_SIZE_X(16), .TEXT_SIZE_Y(6), .FRAMES_PER_CHAR(4), .BLINK_FRAMES(30)
  ) dut (
    .clk(clk), .rst(rst), .module_en(module_en), .start(start), .skip(skip),
    .vga_bus_in(vga_bus_in), .char_code(char_code), .char_xy(char_xy),
    .vga_bus_out(vga_bus_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Push this cycle's expected output, clock once, then compare the entry due now.
  task automatic step(input logic [11:0] exp_rgb);
    sb_t e;
    if (rst) begin
      q.delete();
      e.exp = '0;
      q.push_back(e);
      q.push_back(e);
    end else begin
      e.exp = `VGA_MERGE(hc, vc, hs, vs, hb, vb, exp_rgb);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    skip  = 1'b0;
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("bus_out", 64'(vga_bus_out), 64'(e.exp));
    end
  endtask

  task automatic pt();
    step(rgb_v);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      hc = '0; vc = '0;
      vb = 1'b0; rgb_v = 12'($urandom); pt();
      vb = 1'b1; rgb_v = 12'($urandom); pt();
    end
  endtask

  initial begin
    pix_t tbl[15];
    tbl[0]  = '{11'd247, 11'd200, 1'b0, 1'b1, 8'h00};
    tbl[1]  = '{11'd247, 11'd204, 1'b1, 1'b1, 8'h00};
    tbl[2]  = '{11'd249, 11'd204, 1'b1, 1'b1, 8'h00};
    tbl[3]  = '{11'd251, 11'd204, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{11'd257, 11'd204, 1'b1, 1'b1, 8'h00};
    tbl[5]  = '{11'd259, 11'd204, 1'b1, 1'b1, 8'h00};
    tbl[6]  = '{11'd261, 11'd204, 1'b0, 1'b1, 8'h00};
    tbl[7]  = '{11'd248, 11'd205, 1'b1, 1'b1, 8'h00};
    tbl[8]  = '{11'd249, 11'd222, 1'b1, 1'b1, 8'h00};
    tbl[9]  = '{11'd247, 11'd222, 1'b0, 1'b1, 8'h00};
    tbl[10] = '{11'd262, 11'd231, 1'b0, 1'b1, 8'h00};
    tbl[11] = '{11'd263, 11'd204, 1'b0, 1'b1, 8'h10};
    tbl[12] = '{11'd246, 11'd204, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{11'd247, 11'd199, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{11'd327, 11'd264, 1'b0, 1'b1, 8'h52};

    // reset
    #1;
    rst = 1'b1; pt(); pt();
    rst = 1'b0;
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_reveal", 64'(dut.reveal_cnt), 64'd0);

    // pass-through with module_en low, random bus including in-box pixels
    module_en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      hc = 11'($urandom_range(240, 600)); vc = 11'($urandom_range(190, 420));
      hs = 1'($urandom); vs = 1'($urandom); hb = 1'($urandom); vb = 1'($urandom);
      rgb_v = 12'($urandom); start = 1'($urandom);
      pt();
      chk("pt_done", 64'(done), 64'd0);
    end
    hs = 1'b0; vs = 1'b0; hb = 1'b0;

    // start coinciding with a frame tick: that tick is not counted
    module_en = 1'b1;
    hc = '0; vc = '0; vb = 1'b0; pt();
    start = 1'b1; vb = 1'b1; pt();
    chk("start_reveal0", 64'(dut.reveal_cnt), 64'd0);
    ticks(3);
    chk("reveal_3ticks", 64'(dut.reveal_cnt), 64'd0);
    ticks(1);
    chk("reveal_4ticks", 64'(dut.reveal_cnt), 64'd1);

    // pixel table with only character 0 revealed
    for (int i = 0; i < 15; i++) begin
      hc = tbl[i].h; vc = tbl[i].v; vb = 1'b0; rgb_v = BG;
      #1;
      if (tbl[i].xy_chk) chk("char_xy", 64'(char_xy), 64'(tbl[i].xy));
      step(tbl[i].lit ? COLOUR : BG);
    end

    ticks(376);
    chk("reveal_380", 64'(dut.reveal_cnt), 64'd95);
    ticks(3);
    chk("done_383", 64'(done), 64'd0);
    ticks(1);
    chk("done_384", 64'(done), 64'd1);
    chk("reveal_full", 64'(dut.reveal_cnt), 64'd96);

    // blink: 30 frames visible, 30 hidden, 30 visible
    for (int k = 0; k < 90; k++) begin
      hc = 11'd247; vc = 11'd204; vb = 1'b0; rgb_v = BG;
      step(((k / 30) % 2 == 0) ? COLOUR : BG);
      ticks(1);
    end

    // module_en low forces IDLE on the next clock
    module_en = 1'b0; pt();
    chk("en_off_done", 64'(done), 64'd0);
    chk("en_off_reveal", 64'(dut.reveal_cnt), 64'd0);
    module_en = 1'b1;
    skip = 1'b1; pt();
    chk("skip_idle_done", 64'(done), 64'd0);

    // skip at reveal_cnt = 10, then start+skip restarts
    start = 1'b1; pt();
    ticks(40);
    chk("reveal_10", 64'(dut.reveal_cnt), 64'd10);
    skip = 1'b1; pt();
    chk("skip_done", 64'(done), 64'd1);
    chk("skip_reveal", 64'(dut.reveal_cnt), 64'd96);
    skip = 1'b1; pt();
    chk("skip_show_done", 64'(done), 64'd1);
    start = 1'b1; skip = 1'b1; pt();
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_reveal", 64'(dut.reveal_cnt), 64'd0);
    ticks(4);
    chk("restart_reveal1", 64'(dut.reveal_cnt), 64'd1);
    start = 1'b1; skip = 1'b1; pt();
    chk("restart2_reveal", 64'(dut.reveal_cnt), 64'd0);
    chk("restart2_done", 64'(done), 64'd0);

    // reset at reveal_cnt = 40
    ticks(160);
    chk("reveal_40", 64'(dut.reveal_cnt), 64'd40);
    hc = 11'd5; vc = 11'd7; hs = 1'b1; rgb_v = 12'hABC; rst = 1'b1;
    pt();
    rst = 1'b0;
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_reveal", 64'(dut.reveal_cnt), 64'd0);
    hc = 11'd9; rgb_v = 12'h777; pt();
    hs = 1'b0; pt();
    ticks(8);
    chk("no_start_kept", 64'(dut.reveal_cnt), 64'd0);
    chk("no_start_done", 64'(done), 64'd0);
    pt(); pt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "timeout");
  end
endmodule
